// File: rtl/bcd_disp_sched_pkg.sv
// Shared constants for the shared BCD/seven-segment display scheduler.
package bcd_disp_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CONV = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Active-low segment patterns, bit 0 = segment a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h18;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [5:0] DIGIT_BASE = 6'd10;

endpackage

// File: rtl/bcd_disp_sched_seg7_pattern.sv
// Decimal digit to active-low seven-segment pattern; non-decimal codes blank.
module seg7_pattern
    import bcd_disp_sched_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    // Pure lookup, digits 10..15 show nothing
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_disp_sched.sv
// N requesters share one subtract-10 binary-to-BCD converter and one pair of
// segment lookups; a round-robin arbiter picks who is served next.
module bcd_disp_sched
    import bcd_disp_sched_pkg::*;
#(
    parameter int N          = 4,
    parameter int CH_W       = 2,
    parameter int LEAD_BLANK = 0
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic [N-1:0]        REQ,
    input  logic [6*N-1:0]      VAL,
    output logic [N-1:0]        ACK,
    output logic                BUSY,
    output logic [CH_W-1:0]     GNT_ID,
    output logic [14*N-1:0]     HEX
);

    state_t             r_state;
    state_t             w_next_state;

    logic [CH_W-1:0]    r_ptr;
    logic [CH_W-1:0]    r_gnt;
    logic [5:0]         r_rem;
    logic [2:0]         r_tens;
    logic [N-1:0]       r_ack;
    logic [14*N-1:0]    r_hex;

    logic               w_grant_valid;
    logic [CH_W-1:0]    w_grant_id;
    logic [CH_W-1:0]    w_scan_idx;
    logic [CH_W-1:0]    w_ptr_next;
    logic               w_grant;
    logic               w_conv_step;
    logic               w_conv_fin;
    logic [6:0]         w_tens_pat;
    logic [6:0]         w_ones_pat;
    logic [6:0]         w_tens_seg;

    // Round-robin search starting at r_ptr, wrapping at N
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = '0;
        w_scan_idx    = r_ptr;
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_grant_valid && REQ[w_scan_idx]) begin
                w_grant_valid = 1'b1;
                w_grant_id    = w_scan_idx;
            end
            w_scan_idx = (w_scan_idx == CH_W'(N - 1)) ? '0 : w_scan_idx + 1'b1;
        end
        w_ptr_next = (w_grant_id == CH_W'(N - 1)) ? '0 : w_grant_id + 1'b1;
    end

    // State register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; REQ only matters in IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_grant_valid) w_next_state = ST_CONV;
            ST_CONV: if (r_rem < DIGIT_BASE) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State-decoded control strobes
    always_comb begin
        w_grant     = (r_state == ST_IDLE) && w_grant_valid;
        w_conv_step = (r_state == ST_CONV) && (r_rem >= DIGIT_BASE);
        w_conv_fin  = (r_state == ST_CONV) && (r_rem <  DIGIT_BASE);
        BUSY        = (r_state != ST_IDLE);
    end

    seg7_pattern u_seg_tens (
        .i_digit (4'(r_tens)),
        .o_seg   (w_tens_pat)
    );

    // rem is below 10 whenever the ones pattern is consumed
    seg7_pattern u_seg_ones (
        .i_digit (r_rem[3:0]),
        .o_seg   (w_ones_pat)
    );

    // Optional blanking of a zero tens digit
    always_comb begin
        w_tens_seg = w_tens_pat;
        if ((LEAD_BLANK != 0) && (r_tens == 3'd0)) begin
            w_tens_seg = SEG_BLANK;
        end
    end

    // Grant capture, pointer advance and repeated subtract-10
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_ptr  <= '0;
            r_gnt  <= '0;
            r_rem  <= '0;
            r_tens <= '0;
        end else if (w_grant) begin
            r_rem  <= VAL[6*w_grant_id +: 6];
            r_tens <= '0;
            r_gnt  <= w_grant_id;
            r_ptr  <= w_ptr_next;
        end else if (w_conv_step) begin
            r_rem  <= r_rem - DIGIT_BASE;
            r_tens <= r_tens + 3'd1;
        end
    end

    // Display write and single-cycle acknowledge at the end of conversion
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_ack <= '0;
            r_hex <= '1;
        end else begin
            r_ack <= '0;
            if (w_conv_fin) begin
                r_ack[r_gnt]          <= 1'b1;
                r_hex[14*r_gnt +: 14] <= {w_tens_seg, w_ones_pat};
            end
        end
    end

    assign ACK    = r_ack;
    assign GNT_ID = r_gnt;
    assign HEX    = r_hex;

endmodule

// File: doc/bcd_disp_sched.md
Name: bcd_disp_sched

Overview:
- Shares one iterative binary-to-BCD converter and one seven-segment pattern lookup among N requesters.
- Each requester presents a 6-bit value (0..63) and a request. A round-robin arbiter grants one requester at a time.
- The converter derives tens and ones by repeated subtract-10.
- Active-low segment patterns are written into that requester's two-digit display register, and the requester receives a one-cycle acknowledge.

Parameters:
- N, 4, number of requesters/display channels (2..8).
- CH_W, 2, width of channel index; must equal ceil(log2 N).
- LEAD_BLANK, 0, 1 = show a blank tens digit when tens = 0; 0 = show "0".

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  reset, asynchronous, active-low.
- REQ  in  N  level request per channel.
- VAL  in  6*N  channel c value at VAL[6c+5:6c].
- ACK  out  N  one-cycle completion pulse per channel.
- BUSY  out  1  high whenever the state is not IDLE.
- GNT_ID  out  CH_W  channel currently being served; holds the last served channel in IDLE.
- HEX  out  14*N  channel c at HEX[14c+13:14c]: tens pattern in the upper 7 bits, ones pattern in the lower 7 bits; active-low, bit 0 = segment a.

Behaviour:
- Reset (Resetn = 0, asynchronous):
  - State = IDLE.
  - All HEX registers = 7'h7F (all segments off).
  - ACK = 0, BUSY = 0, GNT_ID = 0, round-robin pointer = 0.
  - Internal rem and tens registers = 0.
  - Reset asserted mid-operation aborts the transaction: no ACK, no display write.
- State machine IDLE -> CONV -> DONE -> IDLE.
- IDLE:
  - If any REQ bit is high, grant the first requesting channel searching ptr, ptr+1, ... mod N.
  - On that edge: latch rem = VAL of the granted channel, tens = 0, GNT_ID = channel, ptr = (channel+1) mod N; go to CONV.
  - If no REQ bit is high, stay in IDLE.
- CONV, one decision per clock:
  - If rem >= 10: rem -= 10, tens += 1, stay in CONV.
  - Else: write HEX[GNT_ID] = {pattern(tens), pattern(rem)}, register ACK[GNT_ID] = 1, go to DONE.
  - tens is 3 bits wide (max 6); rem is 6 bits wide and stays in 0..63.
- DONE:
  - ACK is high for exactly this cycle.
  - Next edge: ACK = 0, go to IDLE.
  - REQ is ignored in CONV and DONE.
- Latency and occupancy:
  - CONV lasts floor(V/10)+1 cycles.
  - ACK is high starting floor(V/10)+1 edges after the grant edge; worst case V = 63 gives 7.
  - Slot occupancy is floor(V/10)+3 cycles, counting IDLE and DONE.
- Requester rule:
  - Deassert REQ on the edge following ACK.
  - A REQ still high in the IDLE after DONE is treated as a new request.
- VAL is sampled only at the grant edge; later changes are ignored.
- REQ dropped mid-conversion: the conversion completes, the display is written and ACK still pulses.
- Pattern table:
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19.
  - 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h18.
  - Values 10..15 = 7'h7F (never reached).
- Tens digit with LEAD_BLANK = 1 and tens = 0: 7'h7F.
- Non-granted channels' HEX registers hold their value indefinitely.

Decomposition:
- Shared package:
  - Segment constants SEG_0..SEG_9 and SEG_BLANK = 7'h7F.
  - State encoding (IDLE = 2'b00, CONV = 2'b01, DONE = 2'b10).
  - DIGIT_BASE = 10.
- One combinational sub-module, seg7_pattern (4-bit in, 7-bit out), instantiated twice (tens, ones).
- The arbiter and subtract loop stay inline.

Test Plan:
- Channel 0, V = 37, single request -> ACK[0] high 4 edges after grant; HEX[13:0] = {7'h30, 7'h78}; other channels stay 7'h7F; BUSY high from the grant edge through DONE.
- Boundaries on channel 1:
  - V = 9 -> latency 1, {7'h40, 7'h18}.
  - V = 10 -> latency 2, {7'h79, 7'h40}.
  - V = 63 -> latency 7, {7'h02, 7'h30}.
  - V = 0 -> {7'h40, 7'h40}; with LEAD_BLANK = 1 -> {7'h7F, 7'h40}.
- REQ = 4'b1111 right after reset, each channel dropping on its ACK -> service order 0, 1, 2, 3. Then REQ = 4'b0101 -> order 0, 2.
- Channel 2 granted with V = 45, VAL[2] changed to 12 and REQ[2] dropped mid-CONV -> HEX channel 2 = {7'h19, 7'h12} and ACK[2] still pulses once.
- Resetn pulled low during CONV for channel 3 (V = 50) -> immediately ACK = 0, BUSY = 0, all HEX = 7'h7F; after release, state is IDLE and ptr = 0.
